// File: rtl/mult_sched_pkg.sv
// rtl/mult_sched_pkg.sv - shared types and defaults for the shift-add multiplier scheduler
package mult_sched_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT,
        S_DONE
    } state_t;

    typedef enum logic [1:0] {
        DP_HOLD,
        DP_LOAD,
        DP_STEP
    } dp_mode_t;

endpackage

// File: rtl/shiftadd_dp.sv
// rtl/shiftadd_dp.sv - shift-add multiply datapath with carry-preserving accumulator
module shiftadd_dp
    import mult_sched_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  dp_mode_t             mode,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic [2*WIDTH-1:0]   prod
);

    logic [WIDTH-1:0]   mcand;
    logic [2*WIDTH:0]   acc;
    logic [WIDTH:0]     sum;

    // Upper-half add is WIDTH+1 bits; the top accumulator bit is always zero here
    // and doubles as the carry slot, so the carry rides into the shift intact.
    always_comb begin
        sum = acc[2*WIDTH:WIDTH] + (acc[0] ? {1'b0, mcand} : '0);
    end

    // Load operands, or perform one conditional-add-then-shift step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand <= '0;
            acc   <= '0;
        end else begin
            case (mode)
                DP_LOAD: begin
                    mcand <= a;
                    acc   <= {1'b0, {WIDTH{1'b0}}, b};
                end
                DP_STEP: begin
                    acc <= {1'b0, sum, acc[WIDTH-1:1]};
                end
                default: begin
                    mcand <= mcand;
                    acc   <= acc;
                end
            endcase
        end
    end

    assign prod = acc[2*WIDTH-1:0];

endmodule

// File: rtl/mult_sched.sv
// rtl/mult_sched.sv - two-requester round-robin scheduler around a shift-add multiplier
module mult_sched
    import mult_sched_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [1:0]           req_i,
    input  logic [WIDTH-1:0]     a0_i,
    input  logic [WIDTH-1:0]     b0_i,
    input  logic [WIDTH-1:0]     a1_i,
    input  logic [WIDTH-1:0]     b1_i,
    output logic [1:0]           ack_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [2*WIDTH-1:0]   prod_o,
    output logic                 id_o
);

    localparam int CW = ($clog2(WIDTH) > 0) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    state_t              state;
    state_t              state_nx;
    dp_mode_t            mode;
    logic [CW-1:0]       cnt;
    logic                prio;
    logic                grant_any;
    logic                grant_id;
    logic                owner;
    logic [WIDTH-1:0]    op_a;
    logic [WIDTH-1:0]    op_b;
    logic [2*WIDTH-1:0]  dp_prod;

    // Arbiter: a lone requester always wins; on contention the favoured one wins.
    always_comb begin
        grant_any = |req_i;
        grant_id  = 1'b0;
        if (req_i == 2'b11) begin
            grant_id = prio;
        end else begin
            grant_id = req_i[1];
        end
    end

    // Next-state and datapath mode.
    always_comb begin
        state_nx = state;
        mode     = DP_HOLD;
        case (state)
            S_IDLE: begin
                if (grant_any) begin
                    state_nx = S_LOAD;
                end
            end
            S_LOAD: begin
                mode     = DP_LOAD;
                state_nx = S_SHIFT;
            end
            S_SHIFT: begin
                mode = DP_STEP;
                if (cnt == LAST_STEP) begin
                    state_nx = S_DONE;
                end
            end
            S_DONE: begin
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    assign busy_o = (state != S_IDLE);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Step counter: runs only while shifting, parked at zero otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (state == S_SHIFT) begin
            cnt <= cnt + 1'b1;
        end else begin
            cnt <= '0;
        end
    end

    // Acceptance: pulse ack, capture the winner's operands and id, rotate priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_o <= '0;
            op_a  <= '0;
            op_b  <= '0;
            owner <= 1'b0;
            prio  <= 1'b0;
        end else begin
            ack_o <= '0;
            if (state == S_IDLE && grant_any) begin
                ack_o <= grant_id ? 2'b10 : 2'b01;
                op_a  <= grant_id ? a1_i : a0_i;
                op_b  <= grant_id ? b1_i : b0_i;
                owner <= grant_id;
                prio  <= ~grant_id;
            end
        end
    end

    // Result registers: captured once per operation and held until the next one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_o <= 1'b0;
            prod_o <= '0;
            id_o   <= 1'b0;
        end else begin
            done_o <= (state == S_DONE);
            if (state == S_DONE) begin
                prod_o <= dp_prod;
                id_o   <= owner;
            end
        end
    end

    shiftadd_dp #(
        .WIDTH (WIDTH)
    ) u_dp (
        .clk   (clk),
        .rst_n (rst_n),
        .mode  (mode),
        .a     (op_a),
        .b     (op_b),
        .prod  (dp_prod)
    );

endmodule

// File: tb/tb_mult_sched.sv
// tb/tb_mult_sched.sv - scoreboard testbench for mult_sched
module tb_mult_sched;

    typedef struct {
        logic [7:0] prod;
        logic       id;
        int         cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] req;
    logic [3:0] a0, b0, a1, b1;
    logic [1:0] ack_o;
    logic       busy_o;
    logic       done_o;
    logic [7:0] prod_o;
    logic       id_o;

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    exp_t sq[$];

    mult_sched #(.WIDTH(4)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .req_i  (req),
        .a0_i   (a0),
        .b0_i   (b0),
        .a1_i   (a1),
        .b1_i   (b1),
        .ack_o  (ack_o),
        .busy_o (busy_o),
        .done_o (done_o),
        .prod_o (prod_o),
        .id_o   (id_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n === 1'b1 && done_o === 1'b1) begin
            if (sq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got done_o=1 prod=%0d want no pending result", prod_o);
            end else begin
                e = sq.pop_front();
                chk("prod", prod_o, e.prod);
                chk("id", id_o, e.id);
                chk("done_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic do_req(input logic [1:0] r, input logic [3:0] x0, input logic [3:0] y0,
                          input logic [3:0] x1, input logic [3:0] y1, input logic [1:0] exp_ack,
                          input logic [7:0] exp_prod, input logic push, output int ack_cyc);
        bit got = 0;
        @(negedge clk);
        req = r; a0 = x0; b0 = y0; a1 = x1; b1 = y1;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (ack_o != 2'b00) got = 1;
        end
        ack_cyc = cyc;
        if (!got) begin
            chk("ack_timeout", 0, 1);
        end else begin
            chk("ack", ack_o, exp_ack);
            if (push) sq.push_back('{exp_prod, exp_ack[1], cyc + 6});
        end
        req = 2'b00;
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && sq.size() > 0; i++) @(negedge clk);
        if (sq.size() > 0) begin
            chk("drain_timeout", sq.size(), 0);
            sq.delete();
        end
    endtask

    initial begin
        int c0;
        int n;
        int done_c;
        bit got;
        bit busy_ok;

        rst_n = 1'b0; req = 2'b00; a0 = 0; b0 = 0; a1 = 0; b1 = 0;
        #1;
        chk("rst_ack", ack_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_prod", prod_o, 0);
        chk("rst_id", id_o, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // single, zero operand, carry case
        do_req(2'b01, 4'd3, 4'd5, 4'd0, 4'd0, 2'b01, 8'd15, 1'b1, c0);
        chk("busy_after_ack", busy_o, 1);
        drain();
        do_req(2'b01, 4'd0, 4'd9, 4'd0, 4'd0, 2'b01, 8'd0, 1'b1, c0);
        drain();
        do_req(2'b10, 4'd0, 4'd0, 4'd15, 4'd15, 2'b10, 8'd225, 1'b1, c0);
        drain();

        // contention: both held, grants alternate starting with requester 0
        @(negedge clk);
        req = 2'b11; a0 = 4'd2; b0 = 4'd3; a1 = 4'd4; b1 = 4'd5;
        n = 0;
        for (int i = 0; i < 80 && n < 4; i++) begin
            @(negedge clk);
            if (ack_o != 2'b00) begin
                chk("rr_ack", ack_o, n[0] ? 2'b10 : 2'b01);
                sq.push_back('{n[0] ? 8'd20 : 8'd6, n[0], cyc + 6});
                n++;
            end
        end
        req = 2'b00;
        chk("rr_grants", n, 4);
        drain();

        // hold-off: requester 1 arrives mid-operation
        do_req(2'b01, 4'd3, 4'd4, 4'd0, 4'd0, 2'b01, 8'd12, 1'b1, c0);
        @(negedge clk);
        req = 2'b10; a1 = 4'd5; b1 = 4'd6;
        got = 0; busy_ok = 1; done_c = -1;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (ack_o != 2'b00) begin
                got = 1;
            end else begin
                if (done_o) done_c = cyc;
                if (done_c < 0 && !busy_o) busy_ok = 0;
            end
        end
        if (!got) begin
            chk("holdoff_timeout", 0, 1);
        end else begin
            chk("holdoff_ack", ack_o, 2'b10);
            chk("holdoff_ack_cycle", cyc, done_c + 1);
            sq.push_back('{8'd30, 1'b1, cyc + 6});
        end
        chk("holdoff_busy", busy_ok, 1);
        req = 2'b00;
        drain();

        // reset during step 2 aborts the operation and restores priority
        do_req(2'b01, 4'd9, 4'd9, 4'd0, 4'd0, 2'b01, 8'd81, 1'b0, c0);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        sq.delete();
        #1;
        chk("mid_rst_ack", ack_o, 0);
        chk("mid_rst_busy", busy_o, 0);
        chk("mid_rst_done", done_o, 0);
        chk("mid_rst_prod", prod_o, 0);
        chk("mid_rst_id", id_o, 0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (8) @(negedge clk);
        do_req(2'b11, 4'd7, 4'd6, 4'd5, 4'd5, 2'b01, 8'd42, 1'b1, c0);
        drain();

        repeat (2) @(negedge clk);
        chk("queue_empty", sq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion want finish before time limit");
        $fatal(1);
    end

endmodule

// File: doc/mult_sched.md
MULT_SCHED -- requirements
Module: mult_sched

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the operand width in bits; the product width is 2*WIDTH.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port req_i, input, 2 bits: per-requester multiply request, one bit per requester 0 and 1.
REQ-005 The block SHALL have ports a0_i and b0_i, input, WIDTH bits each: requester 0 operands, held stable while req_i[0] is high.
REQ-006 The block SHALL have ports a1_i and b1_i, input, WIDTH bits each: requester 1 operands, held stable while req_i[1] is high.
REQ-007 The block SHALL have port ack_o, input-acceptance output, 2 bits: a one-cycle pulse on the accepted requester's bit.
REQ-008 The block SHALL have port busy_o, output, 1 bit: high in every state other than IDLE.
REQ-009 The block SHALL have port done_o, output, 1 bit: a one-cycle pulse marking a valid result.
REQ-010 The block SHALL have port prod_o, output, 2*WIDTH bits: the unsigned product, valid while done_o is high and held until the next done_o.
REQ-011 The block SHALL have port id_o, output, 1 bit: the index of the requester owning prod_o, held with prod_o.

Function
REQ-012 The FSM SHALL have exactly four states: IDLE, LOAD, SHIFT and DONE.
REQ-013 IDLE SHALL transition to LOAD when any req_i bit is high, latching the operands and the winning requester's id, and pulsing that requester's ack_o bit in the same cycle.
REQ-014 When both req_i bits are high, the grant SHALL go to the requester not served last (round-robin); after reset, requester 0 SHALL have priority.
REQ-015 A req_i bit that is high with only one requester active SHALL be granted regardless of the round-robin pointer.
REQ-016 LOAD SHALL drive datapath mode load for one cycle: multiplicand register <= a; accumulator upper half <= 0; lower half <= b; then transition to SHIFT with step counter = 0.
REQ-017 SHIFT SHALL perform one step per cycle for exactly WIDTH cycles: if the accumulator LSB is 1, add the multiplicand to the upper half, then shift the full accumulator right by one, including the carry.
REQ-018 The upper-half add SHALL be WIDTH+1 bits wide so the carry is shifted into the MSB and never lost (for example, 15*15 SHALL yield 225).
REQ-019 After step WIDTH-1 the FSM SHALL transition to DONE; DONE SHALL register prod_o and id_o, pulse done_o for one cycle, and return to IDLE.
REQ-020 Latency SHALL be fixed: done_o SHALL rise WIDTH+2 clk edges after the acceptance edge, and throughput SHALL be one operation per WIDTH+3 cycles.
REQ-021 Requests SHALL be sampled only in IDLE; requests pending in other states SHALL wait, and ack_o SHALL never pulse outside IDLE.
REQ-022 A requester that drops req_i before ack_o SHALL simply not be served, with no error or state effect.
REQ-023 Operands SHALL be treated as unsigned; a zero operand SHALL produce prod_o = 0 with normal latency, with no early exit.

Reset
REQ-024 On rst_n low, the block SHALL asynchronously force state = IDLE; ack_o = 0, busy_o = 0, done_o = 0, prod_o = 0, id_o = 0; round-robin pointer = requester 0; counter and datapath registers = 0.
REQ-025 A reset asserted mid-operation SHALL abort that operation with no done_o; the first request after deassertion SHALL be handled as a fresh request.

Structure
REQ-026 A shared package SHALL hold the state enumeration (IDLE/LOAD/SHIFT/DONE), the datapath mode constants (HOLD/LOAD/STEP) and the default WIDTH.
REQ-027 The datapath SHALL be a separate sub-module, shiftadd_dp, with the multiplicand register, the 2*WIDTH+1-bit accumulator, the mode input and an async active-low reset; mult_sched SHALL contain only the FSM, counter, arbiter and output registers.

Verification
REQ-028 Single request: req_i=01, a0=3, b0=5 -> ack_o=01 on the first edge; done_o 6 edges later with prod_o=15, id_o=0.
REQ-029 Carry case: req_i=10, a1=15, b1=15 -> prod_o=225, id_o=1; zero case: a0=0, b0=9 -> prod_o=0 at the same latency.
REQ-030 Contention: req_i=11 held continuously with a0=2, b0=3, a1=4, b1=5 -> grants alternate 0,1,0,1; results 6,20,6,20; done pulses 7 cycles apart.
REQ-031 Hold-off: req_i[1] raised during SHIFT -> no ack_o until IDLE; its ack_o coincides with the return to IDLE plus one edge; busy_o is high throughout.
REQ-032 Reset mid-SHIFT: rst_n low for 1 cycle during step 2 -> all outputs 0 immediately, no done_o; the next request a0=7, b0=6 -> prod_o=42 with requester-0 priority restored.
